// File: rtl/normalize_pack.sv
// -----------------------------------------------------------------------------
// normalize_pack
//
// Back end of the half-precision adder datapath. It accepts the raw mantissa
// sum, the working (biased) exponent and the result sign from the align/add
// stage. It then normalizes by one bit position per cycle and packs an
// IEEE 754 binary16 result. Zero, overflow (saturate to infinity) and
// underflow (subnormal result) are classified on the way. Rounding is
// truncation (round toward zero) throughout.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1 and rst_n is 1. in_ready is high only in
// IDLE. out_valid is high only in DONE. While out_valid is high, result and the
// flags are held stable until the consumer takes them with out_ready. Only one
// operation is in flight at a time, and there is no bypass from DONE to a new
// accept.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand present
//   in_ready   block can accept (state == IDLE)
//   sign_in    result sign
//   exp_in     working biased exponent of the sum (0 means subnormal scale)
//   mant_in    raw sum: [FRAC_W+1] carry, [FRAC_W] hidden, [FRAC_W-1:0] fraction
//   out_valid  result held valid
//   out_ready  consumer accepts
//   result     packed {sign, exp, frac}
//   zero       result is exact zero
//   ovf        result saturated to infinity
//   unf        result is subnormal
//   state_dbg  current FSM state (IDLE=0, NORM=1, DONE=2) for observation
// -----------------------------------------------------------------------------
module normalize_pack #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign_in,
  input  logic [EXP_W-1:0]        exp_in,
  input  logic [FRAC_W+1:0]       mant_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    zero,
  output logic                    ovf,
  output logic                    unf,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exponent landmarks: all-ones is infinity, all-ones minus one is the
  // largest finite exponent, and one is the subnormal scale.
  localparam logic [EXP_W-1:0]  EXP_INF  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  EXP_TOP  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0]  EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [FRAC_W-1:0] FRAC_NIL = {FRAC_W{1'b0}};

  state_t            state;
  logic              s_r;
  logic [EXP_W-1:0]  exp_r;
  logic [FRAC_W+1:0] mant_r;

  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_r       <= 1'b0;
      exp_r     <= '0;
      mant_r    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_r    <= sign_in;
            // An exponent of zero means the operands were subnormal. Their
            // scale is the same as exponent 1, so normalize from there.
            exp_r  <= (exp_in == '0) ? EXP_ONE : exp_in;
            mant_r <= mant_in;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            state  <= NORM;
          end
        end

        NORM: begin
          // Exactly one action per cycle. The order of these tests matters.
          if (exp_r == EXP_INF) begin
            result    <= {s_r, EXP_INF, FRAC_NIL};
            ovf       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mant_r == '0) begin
            // An exact zero is always reported as +0.
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mant_r[FRAC_W+1]) begin
            if (exp_r == EXP_TOP) begin
              // The carry would push the exponent to infinity.
              result    <= {s_r, EXP_INF, FRAC_NIL};
              ovf       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              // The shifted-out LSB is dropped (truncation).
              mant_r <= mant_r >> 1;
              exp_r  <= exp_r + EXP_ONE;
            end
          end else if (mant_r[FRAC_W]) begin
            result    <= {s_r, exp_r, mant_r[FRAC_W-1:0]};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_r == EXP_ONE) begin
            // Out of exponent range without a hidden bit: pack as subnormal.
            result    <= {s_r, {EXP_W{1'b0}}, mant_r[FRAC_W-1:0]};
            unf       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_r - EXP_ONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_normalize_pack.sv
module tb_normalize_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [4:0]  exp_in;
  logic [11:0] mant_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        ovf;
  logic        unf;
  logic [1:0]  state_dbg;

  int n_checks;
  int n_fail;

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  normalize_pack #(.EXP_W(5), .FRAC_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .unf       (unf),
    .state_dbg (state_dbg)
  );

  // Observed {result, zero, ovf, unf}
  function automatic logic [18:0] obs();
    return {result, zero, ovf, unf};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic start_op(input logic s, input logic [4:0] e, input logic [11:0] m);
    @(negedge clk);
    sign_in  = s;
    exp_in   = e;
    mant_in  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: out_valid=%b in_ready=%b state=%0d expected 0 1 0", out_valid, in_ready, state_dbg);
    end
    n_checks++;
    if (obs() !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_data: {result,zero,ovf,unf}=%h expected %h", obs(), 19'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_right_shift();
    int lat;
    start_op(1'b0, 5'd15, 12'h800);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 2) begin
      n_fail++;
      $display("FAIL rshift_lat: out_valid=%b lat=%0d expected 1 2", out_valid, lat);
    end
    n_checks++;
    if (obs() !== {16'h4000, 3'b000}) begin
      n_fail++;
      $display("FAIL rshift_res: {result,zero,ovf,unf}=%h expected %h", obs(), {16'h4000, 3'b000});
    end
    finish_op();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rshift_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_left_shift();
    int lat;
    start_op(1'b0, 5'd15, 12'h001);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 11) begin
      n_fail++;
      $display("FAIL lshift_lat: out_valid=%b lat=%0d expected 1 11", out_valid, lat);
    end
    n_checks++;
    if (obs() !== {16'h1400, 3'b000}) begin
      n_fail++;
      $display("FAIL lshift_res: {result,zero,ovf,unf}=%h expected %h", obs(), {16'h1400, 3'b000});
    end
    finish_op();
  endtask

  task automatic test_zero();
    int lat;
    start_op(1'b1, 5'd20, 12'h000);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 1) begin
      n_fail++;
      $display("FAIL zero_lat: out_valid=%b lat=%0d expected 1 1", out_valid, lat);
    end
    n_checks++;
    if (obs() !== {16'h0000, 3'b100}) begin
      n_fail++;
      $display("FAIL zero_res: {result,zero,ovf,unf}=%h expected %h", obs(), {16'h0000, 3'b100});
    end
    finish_op();
  endtask

  task automatic test_overflow();
    int lat;
    // carry at exp 30 overflows, positive
    start_op(1'b0, 5'd30, 12'hC00);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 1 || obs() !== {16'h7C00, 3'b010}) begin
      n_fail++;
      $display("FAIL ovf_pos: lat=%0d {result,zero,ovf,unf}=%h expected lat 1 %h", lat, obs(), {16'h7C00, 3'b010});
    end
    finish_op();
    // same, negative
    start_op(1'b1, 5'd30, 12'hC00);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || obs() !== {16'hFC00, 3'b010}) begin
      n_fail++;
      $display("FAIL ovf_neg: {result,zero,ovf,unf}=%h expected %h", obs(), {16'hFC00, 3'b010});
    end
    finish_op();
    // carry at exp 29 lands on exp 30 with no overflow
    start_op(1'b0, 5'd29, 12'h800);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 2 || obs() !== {16'h7800, 3'b000}) begin
      n_fail++;
      $display("FAIL carry_e29: lat=%0d {result,zero,ovf,unf}=%h expected lat 2 %h", lat, obs(), {16'h7800, 3'b000});
    end
    finish_op();
    // latched exponent 31 saturates regardless of mantissa
    start_op(1'b1, 5'd31, 12'h400);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 1 || obs() !== {16'hFC00, 3'b010}) begin
      n_fail++;
      $display("FAIL exp31: lat=%0d {result,zero,ovf,unf}=%h expected lat 1 %h", lat, obs(), {16'hFC00, 3'b010});
    end
    finish_op();
  endtask

  task automatic test_subnormal();
    int lat;
    // one left shift to exp 1, then the hidden bit is still clear
    start_op(1'b0, 5'd2, 12'h100);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 2 || obs() !== {16'h0200, 3'b001}) begin
      n_fail++;
      $display("FAIL subnorm: lat=%0d {result,zero,ovf,unf}=%h expected lat 2 %h", lat, obs(), {16'h0200, 3'b001});
    end
    finish_op();
    // exp 0 latched as 1; a hidden bit makes it normal at exp 1
    start_op(1'b0, 5'd0, 12'h400);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 1 || obs() !== {16'h0400, 3'b000}) begin
      n_fail++;
      $display("FAIL exp0_norm: lat=%0d {result,zero,ovf,unf}=%h expected lat 1 %h", lat, obs(), {16'h0400, 3'b000});
    end
    finish_op();
  endtask

  task automatic test_hold();
    int lat;
    start_op(1'b1, 5'd15, 12'h800);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        sign_in  = 1'b0;
        exp_in   = 5'd20;
        mant_in  = 12'h000;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs() !== {16'hC000, 3'b000}) begin
        n_fail++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b {result,zero,ovf,unf}=%h expected 1 0 %h",
                 i, out_valid, in_ready, obs(), {16'hC000, 3'b000});
      end
    end
    finish_op();
    // the pulse seen in DONE must not have started a new operation
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL hold_no_accept: out_valid=%b in_ready=%b state=%0d expected 0 1 0", out_valid, in_ready, state_dbg);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    start_op(1'b0, 5'd15, 12'h001);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++;
    if (state_dbg !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || obs() !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_mid: state=%0d out_valid=%b in_ready=%b {result,zero,ovf,unf}=%h expected 0 0 1 0",
               state_dbg, out_valid, in_ready, obs());
    end
    start_op(1'b0, 5'd15, 12'h800);
    wait_valid(lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 2 || obs() !== {16'h4000, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: lat=%0d {result,zero,ovf,unf}=%h expected lat 2 %h", lat, obs(), {16'h4000, 3'b000});
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    // out_ready held high throughout: ignored outside DONE, consumed in one cycle
    out_ready = 1'b1;
    start_op(1'b1, 5'd10, 12'h0C0);
    wait_valid(lat);
    // 0x0C0 -> two left shifts to 0x300? no: hidden bit at 10, top set bit 7 -> 3 shifts, exp 7
    n_checks++;
    if (out_valid !== 1'b1 || lat != 4 || obs() !== {1'b1, 5'd7, 10'h200, 3'b000}) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d {result,zero,ovf,unf}=%h expected lat 4 %h", lat, obs(), {1'b1, 5'd7, 10'h200, 3'b000});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    start_op(1'b0, 5'd16, 12'hFFF);
    wait_valid(lat);
    // right shift drops the LSB: 0x7FF -> frac 0x3FF at exp 17
    n_checks++;
    if (out_valid !== 1'b1 || lat != 2 || obs() !== {1'b0, 5'd17, 10'h3FF, 3'b000}) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d {result,zero,ovf,unf}=%h expected lat 2 %h", lat, obs(), {1'b0, 5'd17, 10'h3FF, 3'b000});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    exp_in    = '0;
    mant_in   = '0;

    test_reset();
    test_right_shift();
    test_left_shift();
    test_zero();
    test_overflow();
    test_subnormal();
    test_hold();
    test_reset_mid();
    test_back_to_back();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
